// File: rtl/cmd_pkg.sv
// Shared constants and types for the PC-to-FPGA command link.
package cmd_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hAA;
    localparam logic [7:0] CRC_POLY_DEF  = 8'h07;
    localparam logic [7:0] CRC_INIT_DEF  = 8'h00;

    localparam logic [7:0] CMD_SWAP   = 8'h01;
    localparam logic [7:0] CMD_CLEAR  = 8'h02;
    localparam logic [7:0] CMD_STATUS = 8'h07;

    typedef enum logic [2:0] {
        HUNT,
        LEN,
        CMD,
        PAYLOAD,
        CRC
    } parse_state_e;

endpackage

// File: rtl/crc8_update.sv
// One-byte CRC-8 step, MSB-first, no reflection; shared by receive and transmit paths.
module crc8_update (
    input  logic [7:0] crc_in,
    input  logic [7:0] data_in,
    input  logic [7:0] poly,
    output logic [7:0] crc_out
);

    always_comb begin
        logic [7:0] c;
        c = crc_in ^ data_in;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ poly) : (c << 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/cmd_frame_rx.sv
// Command-frame receiver: sync hunt, LEN/CMD/payload/CRC parse, inter-byte timeout,
// and a register-held output record on a valid/ready handshake.
module cmd_frame_rx
    import cmd_pkg::*;
#(
    parameter int         MAX_PAYLOAD    = 16,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter logic [7:0] CRC_POLY       = CRC_POLY_DEF,
    parameter logic [7:0] CRC_INIT       = CRC_INIT_DEF,
    parameter int         TIMEOUT_CYCLES = 4096,
    localparam int        LW             = $clog2(MAX_PAYLOAD + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     frame_valid,
    input  logic                     frame_ready,
    output logic [7:0]               frame_cmd,
    output logic [LW-1:0]            frame_len,
    output logic [8*MAX_PAYLOAD-1:0] frame_payload,
    output logic                     err_crc,
    output logic                     err_len,
    output logic                     err_timeout,
    output logic                     err_overrun
);

    localparam int         TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0] LEN_MAX = 8'(MAX_PAYLOAD + 2);

    parse_state_e                    state_q, state_d;
    logic [LW-1:0]                   len_q, len_d, idx_q, idx_d;
    logic [7:0]                      cmd_q, cmd_d, crc_q, crc_d, crc_next;
    logic [TW-1:0]                   tmo_q, tmo_d;
    logic [MAX_PAYLOAD-1:0][7:0]     wbuf_q, wbuf_d, obuf_q, obuf_d;
    logic                            frame_valid_q, frame_valid_d;
    logic [7:0]                      frame_cmd_q, frame_cmd_d;
    logic [LW-1:0]                   frame_len_q, frame_len_d;
    logic                            err_crc_q, err_crc_d, err_len_q, err_len_d;
    logic                            err_timeout_q, err_timeout_d, err_overrun_q, err_overrun_d;
    logic                            good_frame;

    crc8_update u_crc (
        .crc_in  (crc_q),
        .data_in (in_data),
        .poly    (CRC_POLY),
        .crc_out (crc_next)
    );

    always_comb begin
        // NOTE: every _d starts from its hold value so no path leaves a latch behind.
        state_d       = state_q;
        len_d         = len_q;
        idx_d         = idx_q;
        cmd_d         = cmd_q;
        crc_d         = crc_q;
        tmo_d         = tmo_q;
        wbuf_d        = wbuf_q;
        obuf_d        = obuf_q;
        frame_valid_d = frame_valid_q;
        frame_cmd_d   = frame_cmd_q;
        frame_len_d   = frame_len_q;
        err_crc_d     = 1'b0;
        err_len_d     = 1'b0;
        err_timeout_d = 1'b0;
        err_overrun_d = 1'b0;
        good_frame    = 1'b0;

        if (in_valid) begin
            tmo_d = '0;
            case (state_q)
                HUNT: if (in_data == SYNC_BYTE) begin
                    state_d = LEN;
                    crc_d   = CRC_INIT;
                    wbuf_d  = '0;
                end
                LEN: if (in_data < 8'd2 || in_data > LEN_MAX) begin
                    err_len_d = 1'b1;
                    state_d   = HUNT;
                end else begin
                    len_d   = LW'(in_data - 8'd2);
                    crc_d   = crc_next;
                    state_d = CMD;
                end
                CMD: begin
                    cmd_d   = in_data;
                    crc_d   = crc_next;
                    idx_d   = '0;
                    state_d = (len_q == '0) ? CRC : PAYLOAD;
                end
                PAYLOAD: begin
                    for (int i = 0; i < MAX_PAYLOAD; i++) begin
                        if (idx_q == LW'(i)) wbuf_d[i] = in_data;
                    end
                    crc_d = crc_next;
                    idx_d = idx_q + LW'(1);
                    if (idx_q + LW'(1) == len_q) state_d = CRC;
                end
                CRC: begin
                    state_d = HUNT;
                    if (in_data == crc_q) good_frame = 1'b1;
                    else                  err_crc_d  = 1'b1;
                end
                default: state_d = HUNT;
            endcase
        end else if (state_q != HUNT) begin
            // A byte landing on the final count takes the in_valid branch instead, so it wins.
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                err_timeout_d = 1'b1;
                state_d       = HUNT;
                tmo_d         = '0;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end

        if (good_frame && frame_valid_q && !frame_ready) begin
            err_overrun_d = 1'b1;
        end else if (good_frame) begin
            obuf_d        = wbuf_q;
            frame_cmd_d   = cmd_q;
            frame_len_d   = len_q;
            frame_valid_d = 1'b1;
        end else if (frame_valid_q && frame_ready) begin
            frame_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= HUNT;
            len_q         <= '0;
            idx_q         <= '0;
            cmd_q         <= '0;
            crc_q         <= '0;
            tmo_q         <= '0;
            // NOTE: both byte buffers are reset so unused payload bytes read 0 straight out of reset.
            wbuf_q        <= '0;
            obuf_q        <= '0;
            frame_valid_q <= 1'b0;
            frame_cmd_q   <= '0;
            frame_len_q   <= '0;
            err_crc_q     <= 1'b0;
            err_len_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            idx_q         <= idx_d;
            cmd_q         <= cmd_d;
            crc_q         <= crc_d;
            tmo_q         <= tmo_d;
            wbuf_q        <= wbuf_d;
            obuf_q        <= obuf_d;
            frame_valid_q <= frame_valid_d;
            frame_cmd_q   <= frame_cmd_d;
            frame_len_q   <= frame_len_d;
            err_crc_q     <= err_crc_d;
            err_len_q     <= err_len_d;
            err_timeout_q <= err_timeout_d;
            err_overrun_q <= err_overrun_d;
        end
    end

    assign frame_valid   = frame_valid_q;
    assign frame_cmd     = frame_cmd_q;
    assign frame_len     = frame_len_q;
    assign frame_payload = obuf_q;
    assign err_crc       = err_crc_q;
    assign err_len       = err_len_q;
    assign err_timeout   = err_timeout_q;
    assign err_overrun   = err_overrun_q;

endmodule

// File: tb/tb_cmd_frame_rx.sv
// Bench for cmd_frame_rx: directed frames plus a random byte stream, checked every cycle
// against a frame-level reference model built from byte queues.
module tb_cmd_frame_rx;

    localparam int         MAXP = 16;
    localparam int         TMO  = 32;
    localparam int         LW   = $clog2(MAXP + 1);
    localparam logic [7:0] SYNC = 8'hAA;

    typedef logic [7:0] bytes_t[$];

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              frame_ready = 1'b0;
    logic              frame_valid;
    logic [7:0]        frame_cmd;
    logic [LW-1:0]     frame_len;
    logic [8*MAXP-1:0] frame_payload;
    logic              err_crc, err_len, err_timeout, err_overrun;

    int n_cmp = 0;
    int n_bad = 0;
    bit rand_ready = 1'b0;

    always #5 clk = ~clk;

    cmd_frame_rx #(
        .MAX_PAYLOAD    (MAXP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .frame_valid   (frame_valid),
        .frame_ready   (frame_ready),
        .frame_cmd     (frame_cmd),
        .frame_len     (frame_len),
        .frame_payload (frame_payload),
        .err_crc       (err_crc),
        .err_len       (err_len),
        .err_timeout   (err_timeout),
        .err_overrun   (err_overrun)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: dut=%0h want=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // CRC as the remainder of the message bit stream (times x^8) divided by x^8+x^2+x+1.
    function automatic logic [7:0] crc_ref(input bytes_t msg);
        logic [7:0] rem = 8'h00;
        foreach (msg[i]) begin
            for (int b = 7; b >= 0; b--) begin
                logic top;
                top = rem[7] ^ msg[i][b];
                rem = rem << 1;
                if (top) rem = rem ^ 8'h07;
            end
        end
        return rem;
    endfunction

    // Reference model: the frame in progress is a queue of bytes starting at SYNC.
    bytes_t            cur;
    bytes_t            body;
    int                idle_cnt = 0;
    bit                m_valid = 1'b0;
    logic [7:0]        m_cmd = 8'h00;
    int                m_len = 0;
    logic [8*MAXP-1:0] m_payload = '0;
    bit                m_crc = 1'b0, m_lenerr = 1'b0, m_tmo = 1'b0, m_ovr = 1'b0;
    bit                got;
    logic [7:0]        f_cmd;
    int                f_len;
    logic [8*MAXP-1:0] f_pl;

    always @(posedge clk) begin
        m_crc = 0; m_lenerr = 0; m_tmo = 0; m_ovr = 0;
        got = 0; f_cmd = 8'h00; f_len = 0; f_pl = '0;
        if (rst) begin
            cur.delete();
            idle_cnt  = 0;
            m_valid   = 0;
            m_cmd     = 8'h00;
            m_len     = 0;
            m_payload = '0;
        end else begin
            if (in_valid) begin
                idle_cnt = 0;
                if (cur.size() != 0 || in_data == SYNC) cur.push_back(in_data);
                if (cur.size() == 2 && (int'(cur[1]) < 2 || int'(cur[1]) > MAXP + 2)) begin
                    m_lenerr = 1;
                    cur.delete();
                end else if (cur.size() >= 4 && cur.size() == int'(cur[1]) + 2) begin
                    body.delete();
                    for (int i = 1; i < cur.size() - 1; i++) body.push_back(cur[i]);
                    if (crc_ref(body) == cur[cur.size() - 1]) begin
                        got   = 1;
                        f_cmd = cur[2];
                        f_len = int'(cur[1]) - 2;
                        for (int i = 0; i < f_len; i++) f_pl[8*i +: 8] = cur[3 + i];
                    end else begin
                        m_crc = 1;
                    end
                    cur.delete();
                end
            end else if (cur.size() != 0) begin
                idle_cnt++;
                if (idle_cnt == TMO) begin
                    m_tmo = 1;
                    cur.delete();
                    idle_cnt = 0;
                end
            end
            if (got && m_valid && !frame_ready) begin
                m_ovr = 1;
            end else if (got) begin
                m_valid   = 1;
                m_cmd     = f_cmd;
                m_len     = f_len;
                m_payload = f_pl;
            end else if (m_valid && frame_ready) begin
                m_valid = 0;
            end
        end
    end

    always begin
        @(posedge clk);
        #2;
        check("valid", frame_valid, m_valid);
        check("err_crc", err_crc, m_crc);
        check("err_len", err_len, m_lenerr);
        check("err_timeout", err_timeout, m_tmo);
        check("err_overrun", err_overrun, m_ovr);
        if (m_valid) begin
            check("cmd", frame_cmd, m_cmd);
            check("len", frame_len, m_len);
            check("payload", frame_payload, m_payload);
        end
    end

    task automatic drive(input logic v, input logic [7:0] d);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        if (rand_ready) frame_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [7:0] d);
        drive(1'b1, d);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'h00);
    endtask

    task automatic send_seq(input bytes_t s);
        foreach (s[i]) send(s[i]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        bytes_t f;
        bytes_t swap;
        swap = {8'hAA, 8'h02, 8'h01, 8'h2D};

        idle(3);
        check("rst_valid", frame_valid, 1'b0);
        check("rst_cmd", frame_cmd, 8'h00);
        check("rst_payload", frame_payload, 128'h0);
        check("rst_errs", {err_crc, err_len, err_timeout, err_overrun}, 4'b0000);
        @(negedge clk) rst = 1'b0;

        body = {8'h02, 8'h01};
        check("model_crc_example", crc_ref(body), 8'h2D);

        frame_ready = 1'b1;
        send_seq(swap); idle(1);
        check("swap_valid", frame_valid, 1'b1);
        check("swap_cmd", frame_cmd, 8'h01);
        check("swap_len", frame_len, 0);

        send_seq({8'h55, 8'h00, 8'hAA, 8'h03, 8'h02, 8'hF0, 8'h49}); idle(1);
        check("noise_cmd", frame_cmd, 8'h02);
        check("noise_len", frame_len, 1);
        check("noise_payload", frame_payload, 128'hF0);

        send_seq({8'hAA, 8'h02, 8'h07, 8'h3E}); idle(1);
        check("badcrc_pulse", err_crc, 1'b1);
        check("badcrc_valid", frame_valid, 1'b0);
        send_seq({8'hAA, 8'h02, 8'h07, 8'h3F}); idle(1);
        check("goodcrc_cmd", frame_cmd, 8'h07);

        send_seq({8'hAA, 8'h01}); idle(1);
        check("len_short", err_len, 1'b1);
        send_seq({8'hAA, 8'(MAXP + 3)}); idle(1);
        check("len_long", err_len, 1'b1);

        body = {8'(MAXP + 2), 8'h02};
        for (int i = 0; i < MAXP; i++) body.push_back(8'(i * 17 + 3));
        f = {SYNC};
        foreach (body[i]) f.push_back(body[i]);
        f.push_back(crc_ref(body));
        send_seq(f); idle(1);
        check("full_valid", frame_valid, 1'b1);
        check("full_len", frame_len, MAXP);
        check("full_top_byte", frame_payload[8*MAXP-1 -: 8], 8'((MAXP - 1) * 17 + 3));

        send_seq({8'hAA, 8'h03, 8'h02}); idle(TMO);
        check("tmo_not_yet", err_timeout, 1'b0);
        idle(1);
        check("tmo_pulse", err_timeout, 1'b1);
        send_seq(swap); idle(1);
        check("after_tmo_cmd", frame_cmd, 8'h01);

        send_seq({8'hAA, 8'h03, 8'h02}); idle(TMO - 1);
        send_seq({8'hF0, 8'h49}); idle(1);
        check("tmo_edge_valid", frame_valid, 1'b1);
        check("tmo_edge_cmd", frame_cmd, 8'h02);

        idle(3);
        frame_ready = 1'b0;
        send_seq(swap);
        send_seq({8'hAA, 8'h02, 8'h07, 8'h3F}); idle(1);
        check("bp_overrun", err_overrun, 1'b1);
        check("bp_cmd_held", frame_cmd, 8'h01);
        idle(2);
        check("bp_still_held", frame_cmd, 8'h01);
        frame_ready = 1'b1;
        idle(2);
        check("bp_drained", frame_valid, 1'b0);

        frame_ready = 1'b0;
        send_seq(swap);
        send_seq({8'hAA, 8'h02, 8'h07});
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h3F; frame_ready = 1'b1;
        idle(1);
        check("swap_accept_cmd", frame_cmd, 8'h07);
        check("swap_accept_valid", frame_valid, 1'b1);
        check("swap_accept_ovr", err_overrun, 1'b0);
        idle(3);

        rand_ready = 1'b1;
        repeat (300) begin
            int kind, pl;
            logic [7:0] lb;
            kind = $urandom_range(0, 19);
            pl   = $urandom_range(0, MAXP);
            repeat ($urandom_range(0, 2)) send(8'($urandom_range(0, 255)));
            lb = (kind == 0) ? 8'($urandom_range(0, 255)) : 8'(pl + 2);
            body = {lb, 8'($urandom_range(0, 255))};
            for (int i = 0; i < pl; i++) body.push_back(8'($urandom_range(0, 255)));
            f = {SYNC};
            foreach (body[i]) f.push_back(body[i]);
            f.push_back(crc_ref(body) ^ ((kind == 1) ? 8'h10 : 8'h00));
            foreach (f[i]) begin
                send(f[i]);
                if (kind == 2 && i == 2) idle(TMO - 1 + $urandom_range(0, 2));
                else if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
            if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 4));
        end

        rand_ready  = 1'b0;
        frame_ready = 1'b1;
        idle(TMO + 5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
